control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_if.sv | 61 ++++++
 rtl/control_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : control_sequencer_if
//  Description : Instruction request and datapath control strobe bundle.
//                The master side issues start/IR and observes the strobes.
//                The slave side (the sequencer) drives the strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
interface control_sequencer_if;

    // Instruction request
    logic        start;
    logic [31:0] IR;

    // Register file strobes (bit n drives register n)
    logic [15:0] Rin;
    logic [15:0] Rout;

    // Datapath strobes
    logic        PCin;
    logic        PCout;
    logic        IRin;
    logic        Yin;
    logic        Zin;
    logic        MARin;
    logic        MDRin;
    logic        MDRout;
    logic        IncPC;
    logic        Read;
    logic        Zlowout;
    logic        Zhighout;
    logic        LOin;
    logic        HIin;

    // ALU operation strobe, one-hot
    logic [12:0] alu_sel;

    // Status
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, IR,
        input  Rin, Rout,
        input  PCin, PCout, IRin, Yin, Zin, MARin, MDRin, MDRout,
        input  IncPC, Read, Zlowout, Zhighout, LOin, HIin,
        input  alu_sel, busy, done, err
    );

    modport slave (
        input  start, IR,
        output Rin, Rout,
        output PCin, PCout, IRin, Yin, Zin, MARin, MDRin, MDRout,
        output IncPC, Read, Zlowout, Zhighout, LOin, HIin,
        output alu_sel, busy, done, err
    );

endinterface
`default_nettype wire

// File: rtl/control_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Hard-wired control unit. Runs a three-cycle fetch (T0-T2)
//                followed by an opcode-dependent execute phase (T3-T6).
//                All strobes are Moore decodes of the state and the operand
//                fields captured at the end of fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer (
    input  wire logic          clk,
    input  wire logic          clr,
    control_sequencer_if.slave bus
);

    // ------------------------------------------------------------------------
    // Types
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_T6   = 3'd7
    } state_t;

    // Execute-phase shape of an opcode
    typedef enum logic [1:0] {
        C_ILLEGAL = 2'd0,
        C_BINARY  = 2'd1,   // Y <- Rb ; Z <- Y op Rc ; Ra <- Zlo
        C_MULDIV  = 2'd2,   // Y <- Ra ; Z <- Y op Rb ; LO <- Zlo ; HI <- Zhi
        C_UNARY   = 2'd3    // Z <- op Rb ; Ra <- Zlo
    } opclass_t;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    state_t      r_state;
    state_t      w_next_state;

    logic [4:0]  r_opcode;
    logic [3:0]  r_ra;
    logic [3:0]  r_rb;
    logic [3:0]  r_rc;

    opclass_t    w_cls;
    logic [12:0] w_alu_onehot;

    logic [15:0] w_ra_dec;
    logic [15:0] w_rb_dec;
    logic [15:0] w_rc_dec;

    logic [15:0] w_rin;
    logic [15:0] w_rout;
    logic        w_pcin;
    logic        w_pcout;
    logic        w_irin;
    logic        w_yin;
    logic        w_zin;
    logic        w_marin;
    logic        w_mdrin;
    logic        w_mdrout;
    logic        w_incpc;
    logic        w_read;
    logic        w_zlowout;
    logic        w_zhighout;
    logic        w_loin;
    logic        w_hiin;
    logic [12:0] w_alu_sel;
    logic        w_busy;
    logic        w_done;
    logic        w_err;

    // Low IR bits carry immediates that this sequencer never looks at.
    logic        w_ir_unused;
    assign w_ir_unused = ^bus.IR[14:0];

    // ------------------------------------------------------------------------
    // State register; reset drops straight to IDLE so every strobe clears.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Capture instruction fields on the T2->T3 edge; execute decodes only
    // these copies so IR may change once fetch is complete.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_opcode <= 5'd0;
            r_ra     <= 4'd0;
            r_rb     <= 4'd0;
            r_rc     <= 4'd0;
        end else if (r_state == S_T2) begin
            r_opcode <= bus.IR[31:27];
            r_ra     <= bus.IR[26:23];
            r_rb     <= bus.IR[22:19];
            r_rc     <= bus.IR[18:15];
        end
    end

    // ------------------------------------------------------------------------
    // Opcode decode: execute class plus the matching one-hot ALU strobe.
    // ------------------------------------------------------------------------
    always_comb begin
        w_cls        = C_ILLEGAL;
        w_alu_onehot = 13'd0;
        case (r_opcode)
            5'b00011: begin w_cls = C_BINARY; w_alu_onehot[0]  = 1'b1; end // ADD
            5'b00100: begin w_cls = C_BINARY; w_alu_onehot[1]  = 1'b1; end // SUB
            5'b00101: begin w_cls = C_BINARY; w_alu_onehot[2]  = 1'b1; end // AND
            5'b00110: begin w_cls = C_BINARY; w_alu_onehot[3]  = 1'b1; end // OR
            5'b00111: begin w_cls = C_BINARY; w_alu_onehot[4]  = 1'b1; end // ROR
            5'b01000: begin w_cls = C_BINARY; w_alu_onehot[5]  = 1'b1; end // ROL
            5'b01001: begin w_cls = C_BINARY; w_alu_onehot[6]  = 1'b1; end // SHR
            5'b01010: begin w_cls = C_BINARY; w_alu_onehot[7]  = 1'b1; end // SHRA
            5'b01011: begin w_cls = C_BINARY; w_alu_onehot[8]  = 1'b1; end // SHL
            5'b01111: begin w_cls = C_MULDIV; w_alu_onehot[9]  = 1'b1; end // MUL
            5'b10000: begin w_cls = C_MULDIV; w_alu_onehot[10] = 1'b1; end // DIV
            5'b10001: begin w_cls = C_UNARY;  w_alu_onehot[11] = 1'b1; end // NEG
            5'b10010: begin w_cls = C_UNARY;  w_alu_onehot[12] = 1'b1; end // NOT
            default:  begin w_cls = C_ILLEGAL; end
        endcase
    end

    // Register-number to one-hot strobe decoders
    assign w_ra_dec = 16'd1 << r_ra;
    assign w_rb_dec = 16'd1 << r_rb;
    assign w_rc_dec = 16'd1 << r_rc;

    // ------------------------------------------------------------------------
    // Next-state: fixed fetch, then an execute path chosen by opcode class.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_next_state = S_T0;
            S_T0:   w_next_state = S_T1;
            S_T1:   w_next_state = S_T2;
            S_T2:   w_next_state = S_T3;
            S_T3: begin
                case (w_cls)
                    C_ILLEGAL: w_next_state = S_IDLE;
                    C_UNARY:   w_next_state = S_T5;   // no second operand
                    default:   w_next_state = S_T4;
                endcase
            end
            S_T4:   w_next_state = S_T5;
            S_T5:   w_next_state = (w_cls == C_MULDIV) ? S_T6 : S_IDLE;
            S_T6:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Moore strobe decode; everything defaults low so only the listed
    // strobes rise in each state.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rin      = 16'd0;
        w_rout     = 16'd0;
        w_pcin     = 1'b0;
        w_pcout    = 1'b0;
        w_irin     = 1'b0;
        w_yin      = 1'b0;
        w_zin      = 1'b0;
        w_marin    = 1'b0;
        w_mdrin    = 1'b0;
        w_mdrout   = 1'b0;
        w_incpc    = 1'b0;
        w_read     = 1'b0;
        w_zlowout  = 1'b0;
        w_zhighout = 1'b0;
        w_loin     = 1'b0;
        w_hiin     = 1'b0;
        w_alu_sel  = 13'd0;
        w_done     = 1'b0;
        w_err      = 1'b0;
        w_busy     = (r_state != S_IDLE);
        case (r_state)
            S_T0: begin
                // MAR <- PC ; Z <- PC + 1
                w_pcout = 1'b1;
                w_marin = 1'b1;
                w_incpc = 1'b1;
                w_zin   = 1'b1;
            end
            S_T1: begin
                // PC <- Z ; MDR <- mem[MAR]
                w_zlowout = 1'b1;
                w_pcin    = 1'b1;
                w_read    = 1'b1;
                w_mdrin   = 1'b1;
            end
            S_T2: begin
                // IR <- MDR
                w_mdrout = 1'b1;
                w_irin   = 1'b1;
            end
            S_T3: begin
                case (w_cls)
                    C_BINARY: begin
                        w_rout = w_rb_dec;
                        w_yin  = 1'b1;
                    end
                    C_MULDIV: begin
                        w_rout = w_ra_dec;
                        w_yin  = 1'b1;
                    end
                    C_UNARY: begin
                        w_rout    = w_rb_dec;
                        w_alu_sel = w_alu_onehot;
                        w_zin     = 1'b1;
                    end
                    default: begin
                        w_err = 1'b1;
                    end
                endcase
            end
            S_T4: begin
                case (w_cls)
                    C_BINARY: begin
                        w_rout    = w_rc_dec;
                        w_alu_sel = w_alu_onehot;
                        w_zin     = 1'b1;
                    end
                    C_MULDIV: begin
                        w_rout    = w_rb_dec;
                        w_alu_sel = w_alu_onehot;
                        w_zin     = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                w_zlowout = 1'b1;
                if (w_cls == C_MULDIV) begin
                    w_loin = 1'b1;
                end else begin
                    w_rin  = w_ra_dec;
                    w_done = 1'b1;
                end
            end
            S_T6: begin
                w_zhighout = 1'b1;
                w_hiin     = 1'b1;
                w_done     = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Drive the bundle
    // ------------------------------------------------------------------------
    assign bus.Rin      = w_rin;
    assign bus.Rout     = w_rout;
    assign bus.PCin     = w_pcin;
    assign bus.PCout    = w_pcout;
    assign bus.IRin     = w_irin;
    assign bus.Yin      = w_yin;
    assign bus.Zin      = w_zin;
    assign bus.MARin    = w_marin;
    assign bus.MDRin    = w_mdrin;
    assign bus.MDRout   = w_mdrout;
    assign bus.IncPC    = w_incpc;
    assign bus.Read     = w_read;
    assign bus.Zlowout  = w_zlowout;
    assign bus.Zhighout = w_zhighout;
    assign bus.LOin     = w_loin;
    assign bus.HIin     = w_hiin;
    assign bus.alu_sel  = w_alu_sel;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.err      = w_err;

endmodule
`default_nettype wire
